// File: rtl/rgb_pwm_decoder.sv
// rtl/rgb_pwm_decoder.sv - recovers a 24-bit RGB value from three PWM LED drive lines
//
// Counts the lit cycles of each channel over free-running windows of PERIOD clocks.
// Because the window length equals the PWM frame length, any window of a steady PWM
// stream contains exactly the on-count, whatever its phase relative to the driver.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   led_r/g/b   PWM lines (pin level is fine; each is synchronized here)
//   rgb_out     last decoded value {r,g,b}, held between updates
//   rgb_valid   one-cycle pulse when rgb_out is updated (every PERIOD cycles)
//   rgb_stable  high when the last two completed windows decoded the same value

module rgb_pwm_decoder #(
   parameter int   PERIOD       = 255,
   parameter logic ACTIVE_LEVEL = 1'b0,
   parameter int   SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        led_r,
   input  logic        led_g,
   input  logic        led_b,
   output logic [23:0] rgb_out,
   output logic        rgb_valid,
   output logic        rgb_stable
);

   localparam logic [7:0] LAST = 8'(PERIOD - 1);

   logic [2:0]                   led_in;
   logic [2:0][SYNC_STAGES-1:0]  sync_q, sync_d;
   logic [2:0]                   active;
   logic                         win_end;
   logic [7:0]                   win_cnt_q, win_cnt_d;
   logic [2:0][7:0]              acc_q, acc_d, sum;
   logic [23:0]                  rgb_out_q, rgb_out_d;
   logic [23:0]                  prev_q, prev_d;
   logic                         rgb_valid_q, rgb_valid_d;
   logic                         rgb_stable_q, rgb_stable_d;
   logic                         first_done_q, first_done_d;

   assign led_in  = {led_r, led_g, led_b};
   assign win_end = (win_cnt_q == LAST);

   always_comb begin
      sync_d       = sync_q;
      active       = '0;
      sum          = '0;
      acc_d        = acc_q;
      win_cnt_d    = win_end ? 8'd0 : win_cnt_q + 8'd1;
      rgb_out_d    = rgb_out_q;
      prev_d       = prev_q;
      rgb_valid_d  = win_end;
      rgb_stable_d = rgb_stable_q;
      first_done_d = first_done_q;

      for (int c = 0; c < 3; c++) begin
         sync_d[c][0] = led_in[c];
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[c][s] = sync_q[c][s-1];
         end
         active[c] = (sync_q[c][SYNC_STAGES-1] == ACTIVE_LEVEL);
         // The final cycle of the window still counts, so the result is acc + active
         sum[c]    = acc_q[c] + {7'd0, active[c]};
         acc_d[c]  = win_end ? 8'd0 : sum[c];
      end

      if (win_end) begin
         rgb_out_d    = sum;
         prev_d       = sum;
         // The very first window after reset never counts as stable
         rgb_stable_d = (sum == prev_q) && first_done_q;
         first_done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q       <= {(3*SYNC_STAGES){~ACTIVE_LEVEL}};
         win_cnt_q    <= 8'd0;
         acc_q        <= '0;
         rgb_out_q    <= 24'd0;
         prev_q       <= 24'd0;
         rgb_valid_q  <= 1'b0;
         rgb_stable_q <= 1'b0;
         first_done_q <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         win_cnt_q    <= win_cnt_d;
         acc_q        <= acc_d;
         rgb_out_q    <= rgb_out_d;
         prev_q       <= prev_d;
         rgb_valid_q  <= rgb_valid_d;
         rgb_stable_q <= rgb_stable_d;
         first_done_q <= first_done_d;
      end
   end

   assign rgb_out    = rgb_out_q;
   assign rgb_valid  = rgb_valid_q;
   assign rgb_stable = rgb_stable_q;

endmodule

// File: tb/tb_rgb_pwm_decoder.sv
// tb/tb_rgb_pwm_decoder.sv - directed bench for rgb_pwm_decoder

module tb_rgb_pwm_decoder;

   logic        clk;
   logic        rst;
   logic        led_r, led_g, led_b;
   logic [23:0] rgb_out;
   logic        rgb_valid, rgb_stable;
   logic        l16;
   logic [23:0] rgb16;
   logic        valid16, stable16;

   int          n_checks = 0;
   int          n_fail   = 0;

   // PWM encoder model state
   bit          enc_on;
   int          enc_abs;
   logic [23:0] enc_val;
   int          chg_at;
   logic [23:0] chg_val;
   int          ph16 = 0;

   rgb_pwm_decoder u_dut (
      .clk        (clk),
      .rst        (rst),
      .led_r      (led_r),
      .led_g      (led_g),
      .led_b      (led_b),
      .rgb_out    (rgb_out),
      .rgb_valid  (rgb_valid),
      .rgb_stable (rgb_stable)
   );

   rgb_pwm_decoder #(.PERIOD(16), .ACTIVE_LEVEL(1'b1), .SYNC_STAGES(2)) u_dut16 (
      .clk        (clk),
      .rst        (rst),
      .led_r      (l16),
      .led_g      (l16),
      .led_b      (l16),
      .rgb_out    (rgb16),
      .rgb_valid  (valid16),
      .rgb_stable (stable16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Active-low lines for the main DUT, active-high for the PERIOD=16 DUT
   task automatic drive();
      int ph;
      if (enc_on) begin
         if (chg_at >= 0 && enc_abs == chg_at) enc_val = chg_val;
         ph    = enc_abs % 255;
         led_r = !(ph < int'(enc_val[23:16]));
         led_g = !(ph < int'(enc_val[15:8]));
         led_b = !(ph < int'(enc_val[7:0]));
         enc_abs++;
      end else begin
         led_r = 1'b1;
         led_g = 1'b1;
         led_b = 1'b1;
      end
      l16  = (ph16 < 5);
      ph16 = (ph16 + 1) % 16;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic wait_valid(input bit sel, input string tag, output int n);
      logic v;
      n = 0;
      v = 1'b0;
      while (!v && n < 400) begin
         cyc();
         n++;
         v = sel ? valid16 : rgb_valid;
      end
      chk({tag, "_seen"}, {31'd0, v}, 32'd1);
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      enc_on = 1'b0;
      drive();
      repeat (3) cyc();
   endtask

   task automatic release_rst(input bit start, input logic [23:0] val, input int chg, input logic [23:0] cval);
      rst     = 1'b0;
      enc_on  = start;
      enc_abs = 0;
      enc_val = val;
      chg_at  = chg;
      chg_val = cval;
      drive();
   endtask

   task automatic start_enc(input logic [23:0] val);
      enc_on  = 1'b1;
      enc_abs = 0;
      enc_val = val;
      chg_at  = -1;
      drive();
   endtask

   int n;
   int offs[3] = '{1, 100, 254};

   initial begin
      enc_on  = 1'b0;
      enc_abs = 0;
      enc_val = 24'd0;
      chg_at  = -1;
      chg_val = 24'd0;
      do_reset();

      chk("reset_rgb_out", {8'd0, rgb_out}, 32'd0);
      chk("reset_valid", {31'd0, rgb_valid}, 32'd0);
      chk("reset_stable", {31'd0, rgb_stable}, 32'd0);
      chk("reset_rgb16", {8'd0, rgb16}, 32'd0);

      // Encoder starts at reset release; lit phases are never lost to sync latency
      release_rst(1'b1, 24'h4080C0, -1, 24'd0);
      wait_valid(1'b0, "t1_w1", n);
      chk("t1_first_latency", n, 255);
      chk("t1_w1_rgb", {8'd0, rgb_out}, 32'h4080C0);
      chk("t1_w1_stable", {31'd0, rgb_stable}, 32'd0);
      cyc();
      chk("t1_pulse_width", {31'd0, rgb_valid}, 32'd0);
      wait_valid(1'b0, "t1_w2", n);
      chk("t1_w2_gap", n, 254);
      chk("t1_w2_rgb", {8'd0, rgb_out}, 32'h4080C0);
      chk("t1_w2_stable", {31'd0, rgb_stable}, 32'd1);
      wait_valid(1'b0, "t1_w3", n);
      chk("t1_w3_gap", n, 255);
      chk("t1_w3_rgb", {8'd0, rgb_out}, 32'h4080C0);
      chk("t1_w3_stable", {31'd0, rgb_stable}, 32'd1);

      // One-cycle reset at win_cnt = 100
      repeat (100) cyc();
      rst = 1'b1;
      cyc();
      chk("rst_mid_rgb_out", {8'd0, rgb_out}, 32'd0);
      chk("rst_mid_valid", {31'd0, rgb_valid}, 32'd0);
      chk("rst_mid_stable", {31'd0, rgb_stable}, 32'd0);
      rst = 1'b0;
      wait_valid(1'b0, "rst_mid_w1", n);
      chk("rst_mid_latency", n, 255);
      chk("rst_mid_w1_stable", {31'd0, rgb_stable}, 32'd0);

      // Extremes: r always lit, g never lit, b lit one cycle per frame
      do_reset();
      release_rst(1'b1, 24'hFF0001, -1, 24'd0);
      wait_valid(1'b0, "ext_w1", n);
      chk("ext_w1_rgb", {8'd0, rgb_out}, 32'hFD0001);
      wait_valid(1'b0, "ext_w2", n);
      chk("ext_w2_rgb", {8'd0, rgb_out}, 32'hFF0001);
      chk("ext_w2_stable", {31'd0, rgb_stable}, 32'd0);
      wait_valid(1'b0, "ext_w3", n);
      chk("ext_w3_rgb", {8'd0, rgb_out}, 32'hFF0001);
      chk("ext_w3_stable", {31'd0, rgb_stable}, 32'd1);

      // Phase sweep
      for (int k = 0; k < 3; k++) begin
         do_reset();
         release_rst(1'b0, 24'd0, -1, 24'd0);
         repeat (offs[k]) cyc();
         start_enc(24'h4080C0);
         repeat (3) wait_valid(1'b0, $sformatf("ph%0d_w", offs[k]), n);
         chk($sformatf("ph%0d_w3_rgb", offs[k]), {8'd0, rgb_out}, 32'h4080C0);
         wait_valid(1'b0, $sformatf("ph%0d_w4", offs[k]), n);
         chk($sformatf("ph%0d_w4_rgb", offs[k]), {8'd0, rgb_out}, 32'h4080C0);
         chk($sformatf("ph%0d_w4_stable", offs[k]), {31'd0, rgb_stable}, 32'd1);
      end

      // Value change at phase 20 of the third frame: window 3 reads 16 + 12 = 0x1C
      do_reset();
      release_rst(1'b1, 24'h101010, 2*255 + 20, 24'h202020);
      wait_valid(1'b0, "chg_w1", n);
      wait_valid(1'b0, "chg_w2", n);
      chk("chg_w2_rgb", {8'd0, rgb_out}, 32'h101010);
      chk("chg_w2_stable", {31'd0, rgb_stable}, 32'd1);
      wait_valid(1'b0, "chg_w3", n);
      chk("chg_w3_rgb", {8'd0, rgb_out}, 32'h1C1C1C);
      chk("chg_w3_stable", {31'd0, rgb_stable}, 32'd0);
      wait_valid(1'b0, "chg_w4", n);
      chk("chg_w4_rgb", {8'd0, rgb_out}, 32'h202020);
      chk("chg_w4_stable", {31'd0, rgb_stable}, 32'd0);
      wait_valid(1'b0, "chg_w5", n);
      chk("chg_w5_rgb", {8'd0, rgb_out}, 32'h202020);
      chk("chg_w5_stable", {31'd0, rgb_stable}, 32'd1);

      // Active-high, PERIOD = 16, on-count 5 on all channels
      do_reset();
      release_rst(1'b0, 24'd0, -1, 24'd0);
      wait_valid(1'b1, "p16_w1", n);
      chk("p16_first_latency", n, 16);
      wait_valid(1'b1, "p16_w2", n);
      chk("p16_w2_gap", n, 16);
      chk("p16_w2_rgb", {8'd0, rgb16}, 32'h050505);
      wait_valid(1'b1, "p16_w3", n);
      chk("p16_w3_gap", n, 16);
      chk("p16_w3_rgb", {8'd0, rgb16}, 32'h050505);
      chk("p16_w3_stable", {31'd0, stable16}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rgb_pwm_decoder.md
# rgb_pwm_decoder

Recovers the 24-bit RGB value from the three PWM LED drive lines produced by the RGB LED driver. It counts active cycles per channel over fixed windows of one PWM frame length. Sits on the board-side loopback path, so self-test and debug logic can read back what the LED driver is actually emitting, including the effect of blinking. Single clock domain; the PWM inputs pass through a synchronizer so pin-level signals are also acceptable.

## Interface
- PERIOD, 255: PWM frame length in clk cycles; legal range 2..255; must equal the driver's frame length.
- ACTIVE_LEVEL, 1'b0: input level meaning "LED lit"; 0 matches the pull-up, active-low LED lines.
- SYNC_STAGES, 2: synchronizer flops per input; legal range 1..3.
- clk  input  1  system clock (27 MHz).
- rst  input  1  reset; synchronous, active-high.
- led_r  input  1  red PWM line.
- led_g  input  1  green PWM line.
- led_b  input  1  blue PWM line.
- rgb_out  output  24  last decoded value, {r,g,b}, 8 bits each.
- rgb_valid  output  1  one-cycle pulse when rgb_out is updated.
- rgb_stable  output  1  high when the last two completed windows decoded identical values.

## Operation
- Each input passes through SYNC_STAGES flops. On reset these flops load ~ACTIVE_LEVEL, the inactive level.
- Per channel, sample active = (synchronized input == ACTIVE_LEVEL).
- Window counter win_cnt, 8 bits:
  - 0 on reset.
  - Increments every cycle and wraps PERIOD-1 -> 0.
  - Free-running; no phase alignment to the driver.
- Per-channel accumulator acc, 8 bits:
  - When win_cnt != PERIOD-1: acc <= acc + active.
  - When win_cnt == PERIOD-1: the result is acc + active. This result is registered into the channel's rgb_out byte, and acc is cleared to 0.
  - acc cannot overflow, because PERIOD <= 255.
- Phase independence: any PERIOD-cycle window of a periodic signal with period PERIOD contains exactly the on-count. The decode is therefore exact at any phase offset.
- A constant-inactive channel decodes to 0. A constant-active channel decodes to PERIOD (0xFF at the default).
- rgb_stable and the previous-result register prev:
  - Both update at each window end.
  - rgb_stable <= (new result == prev) && (first window already completed).
  - prev <= new result.
- Value or blink changes mid-window yield one mixed window. The decoded value is exact in the first full window after the change. rgb_stable asserts on the second consecutive equal window.
- Blink handling:
  - During the driver's blink-off half-period, all channels decode 0.
  - Windows straddling a blink edge are mixed.
  - No special handling; consumers qualify readings with rgb_stable.

## Timing
- Reset values: rgb_out = 0, rgb_valid = 0, rgb_stable = 0, win_cnt = 0, acc = 0, prev = 0, synchronizer flops inactive.
- rst takes priority over all other updates. Asserting it mid-window discards the partial window; the next edge shows the reset values.
- Input latency: a pin edge is visible to acc SYNC_STAGES cycles later.
- rgb_valid:
  - Counting clock edges after rst deasserts from edge 1, win_cnt == PERIOD-1 during the cycle before edge PERIOD.
  - rgb_out, rgb_stable and rgb_valid all change at edge PERIOD.
  - rgb_valid is high for exactly one cycle; it then pulses every PERIOD cycles.
- The first window after reset includes SYNC_STAGES cycles of inactive synchronizer output, so it may read low by up to SYNC_STAGES. rgb_stable is 0 after the first window regardless of value.
- rgb_out holds its value between pulses. There is no ready/backpressure; a consumer that misses a pulse simply reads the held value.

## Test plan
- Active-low PWM lines from an encoder model, frame 255, rgb = 0x4080C0 (each channel lit for cycle < value), starting at reset release:
  - 2nd rgb_valid: rgb_out = 0x4080C0, rgb_stable = 1.
  - Pulses repeat every 255 cycles with identical values.
- Extremes, lines held at r = constant 0, g = constant 1, b = PWM 0x01:
  - rgb_out = 0xFF0001 from the 2nd window on.
- Phase sweep: same 0x4080C0 stream, started at offsets 1, 100 and 254 cycles after reset release:
  - rgb_out = 0x4080C0 from the first full window onward at every offset.
- Value change 0x101010 -> 0x202020 in mid-window:
  - The window containing the change reads neither value exactly, rgb_stable = 0.
  - Next window: 0x202020, rgb_stable = 0.
  - Following window: 0x202020, rgb_stable = 1.
- rst pulsed for 1 cycle while win_cnt = 100:
  - Next edge shows all outputs 0.
  - The next rgb_valid appears exactly PERIOD edges after rst deasserts.
- ACTIVE_LEVEL = 1, PERIOD = 16, active-high PWM with on-count 5 per channel:
  - rgb_out = 0x050505.
  - rgb_valid period = 16 cycles.
